// File: rtl/hdmi_ctrl_pkg.sv
// Shared types and helpers for the HDMI output sequencer: FSM states,
// display mode encodings and the mode-advance rule.
package hdmi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FILL,
    RUN,
    RESYNC
  } state_t;

  localparam logic [1:0] MODE_RGB  = 2'd0;
  localparam logic [1:0] MODE_GREY = 2'd1;
  localparam logic [1:0] MODE_TH   = 2'd2;

  // Cycles RGB -> GREY -> THRESHOLD -> RGB; the unused code 3 also maps to RGB.
  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    case (mode)
      MODE_RGB:  return MODE_GREY;
      MODE_GREY: return MODE_TH;
      default:   return MODE_RGB;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for an asynchronous push-button.
// The output changes only after DEBOUNCE_CYCLES consecutive samples at the new level.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level
);

  logic [1:0]  sync_q;
  logic [19:0] cnt;

  // NOTE: the first flop may go metastable; only sync_q[1] is used by any logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_n};
    end
  end

  // Any sample matching the accepted level (a bounce back) restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync_q[1] == level) begin
      cnt <= '0;
    end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
      level <= sync_q[1];
      cnt   <= '0;
    end else begin
      cnt <= cnt + 20'd1;
    end
  end

endmodule

// File: rtl/hdmi_display_ctrl.sv
// HDMI output sequencer: holds the timing generator until the line FIFO is primed,
// gates FIFO reads, flags underflow, and applies the display mode at frame boundaries.
module hdmi_display_ctrl
  import hdmi_ctrl_pkg::*;
#(
  parameter int unsigned START_LEVEL     = 1568,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter int unsigned FILL_W          = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_frame_start,
  input  logic [FILL_W-1:0] fifo_level,
  input  logic              fifo_empty,
  input  logic              pix_req,
  input  logic              vs,
  input  logic              mode_btn_n,
  output logic              hdmi_en,
  output logic              fifo_rd,
  output logic [1:0]        slo,
  output logic              underflow,
  output logic [7:0]        frame_cnt
);

  localparam logic [FILL_W-1:0] START_LVL = FILL_W'(START_LEVEL);

  state_t     state;
  logic       btn_level;
  logic       btn_level_q;
  logic       vs_q;
  logic       frame_tick;
  logic [1:0] pending_mode;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(mode_btn_n),
    .level(btn_level)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hdmi_en   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cam_frame_start) state <= WAIT_FILL;
        end
        WAIT_FILL: begin
          if (fifo_level >= START_LVL) begin
            state   <= RUN;
            hdmi_en <= 1'b1;
          end
        end
        // A camera frame start here is deliberately ignored: the display free-runs.
        RUN: begin
          if (pix_req && fifo_empty) begin
            state     <= RESYNC;
            hdmi_en   <= 1'b0;
            underflow <= 1'b1;
          end
        end
        RESYNC: begin
          if (cam_frame_start) state <= WAIT_FILL;
        end
        default: begin
          state   <= IDLE;
          hdmi_en <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd = pix_req && (state == RUN) && !fifo_empty;

  // A press that coincides with a boundary lands in pending_mode after slo has
  // already sampled the old value, so it waits for the following boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q         <= 1'b1;
      frame_tick   <= 1'b0;
      btn_level_q  <= 1'b1;
      pending_mode <= MODE_RGB;
      slo          <= MODE_RGB;
      frame_cnt    <= 8'd0;
    end else begin
      vs_q        <= vs;
      frame_tick  <= vs_q && !vs && (state == RUN);
      btn_level_q <= btn_level;
      if (btn_level_q && !btn_level) pending_mode <= next_mode(pending_mode);
      if ((state != RUN) || frame_tick) slo <= pending_mode;
      if (frame_tick) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_hdmi_display_ctrl.sv
// Self-checking bench for hdmi_display_ctrl: table-driven FSM vectors plus
// hand-written mode, frame-count and asynchronous-reset sequences.
module tb_hdmi_display_ctrl;

  localparam int          DB     = 8;
  localparam int unsigned FILL_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cam_frame_start;
  logic [FILL_W-1:0] fifo_level;
  logic              fifo_empty;
  logic              pix_req;
  logic              vs;
  logic              mode_btn_n;
  logic              hdmi_en;
  logic              fifo_rd;
  logic [1:0]        slo;
  logic              underflow;
  logic [7:0]        frame_cnt;

  hdmi_display_ctrl #(
    .START_LEVEL    (1568),
    .DEBOUNCE_CYCLES(20'(DB)),
    .FILL_W         (FILL_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cam_frame_start(cam_frame_start),
    .fifo_level     (fifo_level),
    .fifo_empty     (fifo_empty),
    .pix_req        (pix_req),
    .vs             (vs),
    .mode_btn_n     (mode_btn_n),
    .hdmi_en        (hdmi_en),
    .fifo_rd        (fifo_rd),
    .slo            (slo),
    .underflow      (underflow),
    .frame_cnt      (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              cfs;
    logic [FILL_W-1:0] level;
    logic              empty;
    logic              req;
    logic              exp_rd;
    logic              exp_en;
    logic              exp_uf;
  } vec_t;

  typedef struct {
    logic [1:0] slo;
    logic [7:0] cnt;
  } frm_t;

  vec_t       vecs[13];
  logic [1:0] q_ctl[$];
  frm_t       q_frm[$];

  int checks = 0;
  int errors = 0;
  int slo_m  = 0;
  int pend_m = 0;
  int cnt_m  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the button low for low_cycles, then release long enough to settle high.
  task automatic press(input int low_cycles);
    mode_btn_n = 1'b0;
    repeat (low_cycles) tick();
    mode_btn_n = 1'b1;
    repeat (DB + 6) tick();
    if (low_cycles >= DB) pend_m = (pend_m + 1) % 3;
  endtask

  task automatic frame_boundary(input string tag);
    frm_t e;
    vs = 1'b0;
    cnt_m = (cnt_m + 1) % 256;
    q_frm.push_back('{slo: 2'(pend_m), cnt: 8'(cnt_m)});
    tick();
    check({tag, "_slo_edge1"}, 32'(slo), 32'(slo_m));
    tick();
    e = q_frm.pop_front();
    check({tag, "_slo"}, 32'(slo), 32'(e.slo));
    check({tag, "_cnt"}, 32'(frame_cnt), 32'(e.cnt));
    slo_m = pend_m;
    vs = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    logic [1:0] e;

    vecs[0]  = '{1'b0, 12'd1600, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 12'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 12'd1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 12'd1567, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 12'd1568, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 12'd1568, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 12'd1568, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 12'd1568, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 12'd1568, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 12'd1568, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 12'd2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 12'd2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 12'd2000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst_n           = 1'b0;
    cam_frame_start = 1'b0;
    fifo_level      = '0;
    fifo_empty      = 1'b0;
    pix_req         = 1'b1;
    vs              = 1'b1;
    mode_btn_n      = 1'b1;
    tick();
    tick();
    check("rst_en",  32'(hdmi_en),   32'(0));
    check("rst_rd",  32'(fifo_rd),   32'(0));
    check("rst_slo", 32'(slo),       32'(0));
    check("rst_uf",  32'(underflow), 32'(0));
    check("rst_cnt", 32'(frame_cnt), 32'(0));
    pix_req = 1'b0;
    rst_n   = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      cam_frame_start = vecs[i].cfs;
      fifo_level      = vecs[i].level;
      fifo_empty      = vecs[i].empty;
      pix_req         = vecs[i].req;
      #1;
      check($sformatf("vec%0d_rd", i), 32'(fifo_rd), 32'(vecs[i].exp_rd));
      q_ctl.push_back({vecs[i].exp_en, vecs[i].exp_uf});
      @(posedge clk);
      #1;
      e = q_ctl.pop_front();
      check($sformatf("vec%0d_en", i), 32'(hdmi_en),   32'(e[1]));
      check($sformatf("vec%0d_uf", i), 32'(underflow), 32'(e[0]));
    end
    cam_frame_start = 1'b0;
    pix_req         = 1'b0;
    fifo_empty      = 1'b0;
    tick();

    press(DB + 6);
    check("press1_hold", 32'(slo), 32'(slo_m));
    frame_boundary("press1");
    press(DB + 6);
    press(DB + 6);
    press(DB + 6);
    check("press3_hold", 32'(slo), 32'(slo_m));
    frame_boundary("press3");
    press(DB - 1);
    frame_boundary("bounce");
    press(DB);
    frame_boundary("stable");
    press(DB + 6);
    frame_boundary("wrap");
    press(DB + 6);
    frame_boundary("final");

    pix_req = 1'b1;
    #1;
    check("pre_rst_rd", 32'(fifo_rd), 32'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_en",  32'(hdmi_en),   32'(0));
    check("async_rd",  32'(fifo_rd),   32'(0));
    check("async_slo", 32'(slo),       32'(0));
    check("async_uf",  32'(underflow), 32'(0));
    check("async_cnt", 32'(frame_cnt), 32'(0));
    tick();
    pix_req    = 1'b0;
    fifo_level = 12'd2000;
    rst_n      = 1'b1;
    slo_m = 0;
    pend_m = 0;
    cnt_m = 0;
    repeat (3) tick();
    check("no_cfs_en", 32'(hdmi_en), 32'(0));
    cam_frame_start = 1'b1;
    tick();
    cam_frame_start = 1'b0;
    tick();
    check("rerun_en", 32'(hdmi_en), 32'(1));

    for (int f = 0; f < 260; f++) begin
      vs = 1'b0;
      tick();
      tick();
      vs = 1'b1;
      tick();
      tick();
      cnt_m = (cnt_m + 1) % 256;
    end
    check("cnt_260", 32'(frame_cnt), 32'(cnt_m));
    check("cnt_260_abs", 32'(frame_cnt), 32'(4));

    pix_req    = 1'b1;
    fifo_empty = 1'b1;
    #1;
    check("uf_rd", 32'(fifo_rd), 32'(0));
    tick();
    pix_req = 1'b0;
    check("uf_flag", 32'(underflow), 32'(1));
    check("uf_en",   32'(hdmi_en),   32'(0));
    press(DB + 6);
    check("resync_slo", 32'(slo), 32'(pend_m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_display_ctrl.md
# hdmi_display_ctrl

Sequencer for the HDMI output path. It holds the 640x480 timing generator idle until the camera line FIFO has buffered enough pixels after a camera frame start, then enables it. It gates FIFO reads to the generator's pixel requests, detects underflow and resynchronises on the next camera frame. It also owns the display mode select (RGB / GREY / THRESHOLD): a debounced push-button cycles the mode, and the change is applied only at a frame boundary.

## Interface
Parameters:
- START_LEVEL, 1568: FIFO fill level (pixels) required before enabling output; two 784-pixel lines.
- DEBOUNCE_CYCLES, 20'd500000: number of stable samples needed to accept a button level.
- FILL_W, 12: width of the FIFO fill-level bus.

Ports:
- clk  in  1  pixel clock; also used as the HDMI pclk.
- rst_n  in  1  asynchronous, active-low reset.
- cam_frame_start  in  1  one-cycle pulse at camera frame start; already synchronous to clk.
- fifo_level  in  FILL_W  current line-FIFO occupancy.
- fifo_empty  in  1  line FIFO empty flag.
- pix_req  in  1  pixel request from the timing generator (its pre-DE).
- vs  in  1  vertical sync from the timing generator; low during sync.
- mode_btn_n  in  1  raw mode push-button; active-low; asynchronous.
- hdmi_en  out  1  level. High enables the timing generator; low holds it at count 0.
- fifo_rd  out  1  FIFO read strobe.
- slo  out  2  display mode: 0 RGB, 1 GREY, 2 THRESHOLD.
- underflow  out  1  sticky underflow flag.
- frame_cnt  out  8  number of displayed frames, wrapping.

## Operation
- The state machine has four states: IDLE, WAIT_FILL, RUN and RESYNC.
  - IDLE: on cam_frame_start, go to WAIT_FILL.
  - WAIT_FILL: when fifo_level >= START_LEVEL, go to RUN.
  - RUN: on pix_req && fifo_empty, set underflow and go to RESYNC.
  - RESYNC: on cam_frame_start, go to WAIT_FILL.
- hdmi_en = 1 only in RUN (registered).
- fifo_rd = pix_req && (state==RUN) && !fifo_empty. This is combinational, so the read is issued in the same cycle as pix_req.
- If cam_frame_start arrives while in RUN, it is ignored. Free-running display does not re-align mid-stream.
- underflow is sticky. Only rst_n clears it.
- Frame boundary = vs falling edge, detected against a registered copy of vs and qualified by RUN.
- frame_cnt increments at each frame boundary. It wraps from 255 to 0.
- Mode control:
  - The button path is a 2-FF synchroniser followed by the debouncer.
  - Each debounced press (1→0 transition) advances pending_mode 0→1→2→0. Value 3 is never produced.
  - At each frame boundary, slo <= pending_mode. Outside RUN, slo <= pending_mode every cycle, since no frame is on screen.
- Multiple presses within one frame accumulate in pending_mode; only the final value is applied.
- A boundary and a press in the same cycle: slo takes the pre-press pending value, and the press is applied at the next boundary.

## Timing
Reset values:
- State IDLE.
- hdmi_en = 0, slo = 0, underflow = 0, frame_cnt = 0, pending_mode = 0.
- Debounced button level 1, debounce counter 0.
- fifo_rd = 0, because state is not RUN.

Latencies:
- cam_frame_start to WAIT_FILL: 1 cycle.
- Level-met to hdmi_en high: 1 cycle.
- Underflow detect to underflow = 1 and hdmi_en = 0: 1 cycle. The offending pix_req does not produce fifo_rd.
- vs falling edge to slo/frame_cnt update: 2 cycles (1 cycle for the edge register, 1 for the update).
- Button: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 cycle before pending_mode updates. A bounce resets the debounce counter.

Reset mid-operation:
- All outputs return to their reset values asynchronously.
- Resumption requires a fresh cam_frame_start.

## Structure
- Package hdmi_ctrl_pkg contains:
  - the state enum (IDLE, WAIT_FILL, RUN, RESYNC);
  - mode constants MODE_RGB = 2'd0, MODE_GREY = 2'd1, MODE_TH = 2'd2;
  - the mode-advance function (wraps 2→0).
- Sub-module btn_debounce holds the 2-FF synchroniser and stability counter. Its output is the debounced level; the falling-edge detect stays in the top block.

## Test plan
- Reset, cam_frame_start, ramp fifo_level 0→1568 → hdmi_en rises exactly 1 cycle after level reaches 1568, not at 1567.
- RUN with fifo_empty = 1 while pix_req = 1 → fifo_rd stays 0, underflow = 1 and hdmi_en = 0 next cycle; hdmi_en re-asserts only after a new cam_frame_start plus refill.
- Press button once mid-frame → slo stays 0 until the vs fall, then becomes 1 two cycles after the edge; three presses in one frame → slo = 0 at the boundary.
- Button bounces 1 cycle shorter than DEBOUNCE_CYCLES → no mode change; a stable press → exactly one advance.
- 260 vs falling edges in RUN → frame_cnt = 4.
- rst_n low during RUN mid-line → hdmi_en, fifo_rd, slo, underflow and frame_cnt all 0 immediately, without waiting for a clock edge.
